spi_daisy_master: RTL and testbench

Parametrised SPI master for daisy-chained slaves. It shifts one frame of `p_NUM_DEV` words through the whole chain in a single chip-select window. It supports all four SPI modes through runtime CPOL/CPHA and has programmable chip-select setup/hold. It sits between a host-side word interface and the chain, with MOSI feeding device 0 and device `p_NUM_DEV-1` driving MISO; it replaces the single-word master plus an external `ss` in chained designs.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sclk_gen.sv | 65 ++++++
 rtl/spi_daisy_master.sv | 158 +++++++++++++++
 tb/tb_spi_daisy_master.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the daisy-chain SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } spi_state_t;

  // Mode encoding is {CPOL, CPHA}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int bit_cnt_w(input int n_dev, input int word_len);
    return $clog2(2 * n_dev * word_len + 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: half-period down-counter, SCLK register and edge strobes.
// Strobes are asserted in the cycle whose closing i_clk edge toggles SCLK.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int p_CLK_DIV  = 10,
  parameter int p_NUM_DEV  = 2,
  parameter int p_WORD_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_cpol,
  output logic o_sclk,
  output logic o_lead,
  output logic o_trail,
  output logic o_last
);

  localparam int DIV_W     = (p_CLK_DIV > 1) ? $clog2(p_CLK_DIV) : 1;
  localparam int EDGE_W    = bit_cnt_w(p_NUM_DEV, p_WORD_LEN);
  localparam int NUM_EDGES = 2 * p_NUM_DEV * p_WORD_LEN;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              sclk_q, sclk_d;
  logic              tick;

  always_comb begin
    tick   = i_en && (div_q == '0);
    div_d  = div_q;
    edge_d = edge_q;
    sclk_d = sclk_q;
    if (!i_en) begin
      // Parked: SCLK follows the polarity that the next frame will use.
      div_d  = DIV_W'(p_CLK_DIV - 1);
      edge_d = '0;
      sclk_d = i_cpol;
    end else if (tick) begin
      div_d  = DIV_W'(p_CLK_DIV - 1);
      edge_d = edge_q + 1'b1;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q  <= DIV_W'(p_CLK_DIV - 1);
      edge_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
    end
  end

  assign o_sclk  = sclk_q;
  assign o_lead  = tick && !edge_q[0];
  assign o_trail = tick && edge_q[0];
  assign o_last  = tick && (edge_q == EDGE_W'(NUM_EDGES - 1));

endmodule

// File: rtl/spi_daisy_master.sv
// SPI master shifting one N-word frame through a daisy chain per CS window.
// Shared TX/RX shift register; the state machine and all outputs are registered.
module spi_daisy_master
  import spi_pkg::*;
#(
  parameter int p_WORD_LEN = 8,
  parameter int p_NUM_DEV  = 2,
  parameter int p_CLK_DIV  = 10,
  parameter int p_CS_SETUP = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_cpol,
  input  logic                           i_cpha,
  input  logic [p_WORD_LEN*p_NUM_DEV-1:0] i_data,
  input  logic                           i_dv,
  input  logic                           i_miso,
  output logic                           o_ready,
  output logic                           o_sclk,
  output logic                           o_mosi,
  output logic                           o_ss_n,
  output logic                           o_active,
  output logic [p_WORD_LEN*p_NUM_DEV-1:0] o_data,
  output logic                           o_dv
);

  localparam int FRAME_W = p_WORD_LEN * p_NUM_DEV;
  localparam int TMR_W   = (p_CS_SETUP > 1) ? $clog2(p_CS_SETUP) : 1;

  spi_state_t         state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               rx_q, rx_d;
  logic               mosi_q, mosi_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               ss_n_q, ss_n_d;
  logic               ready_q, ready_d;
  logic               dv_q, dv_d;

  logic shift_en, sclk, lead, trail, last;

  assign shift_en = (state_q == ST_SHIFT);

  spi_sclk_gen #(
    .p_CLK_DIV  (p_CLK_DIV),
    .p_NUM_DEV  (p_NUM_DEV),
    .p_WORD_LEN (p_WORD_LEN)
  ) u_sclk_gen (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (shift_en),
    .i_cpol  (cpol_d),
    .o_sclk  (sclk),
    .o_lead  (lead),
    .o_trail (trail),
    .o_last  (last)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sr_d    = sr_q;
    data_d  = data_q;
    rx_d    = rx_q;
    mosi_d  = mosi_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    ss_n_d  = ss_n_q;
    ready_d = ready_q;
    dv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (ready_q && i_dv) begin
          state_d = ST_SETUP;
          ready_d = 1'b0;
          ss_n_d  = 1'b0;
          sr_d    = i_data;
          cpol_d  = i_cpol;
          cpha_d  = i_cpha;
          tmr_d   = TMR_W'(p_CS_SETUP - 1);
          if (!i_cpha) mosi_d = i_data[FRAME_W-1];
        end
      end
      ST_SETUP: begin
        if (tmr_q == '0) state_d = ST_SHIFT;
        else             tmr_d   = tmr_q - 1'b1;
      end
      ST_SHIFT: begin
        if (!cpha_q) begin
          // Sample on the leading edge, shift and present the next bit on the trailing one.
          if (lead) rx_d = i_miso;
          if (trail) begin
            sr_d = {sr_q[FRAME_W-2:0], rx_q};
            if (!last) mosi_d = sr_q[FRAME_W-2];
          end
        end else begin
          if (lead)  mosi_d = sr_q[FRAME_W-1];
          if (trail) sr_d   = {sr_q[FRAME_W-2:0], i_miso};
        end
        if (last) begin
          state_d = ST_HOLD;
          tmr_d   = TMR_W'(p_CS_SETUP - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
          ss_n_d  = 1'b1;
          dv_d    = 1'b1;
          data_d  = sr_q;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      rx_q    <= 1'b0;
      mosi_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      ready_q <= 1'b1;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      rx_q    <= rx_d;
      mosi_q  <= mosi_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      ss_n_q  <= ss_n_d;
      ready_q <= ready_d;
      dv_q    <= dv_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_sclk   = sclk;
  assign o_mosi   = mosi_q;
  assign o_ss_n   = ss_n_q;
  assign o_active = ~ss_n_q;
  assign o_data   = data_q;
  assign o_dv     = dv_q;

endmodule

// File: tb/tb_spi_daisy_master.sv
// Bench: two chain configurations, each driven against a behavioural slave chain.
module tb_spi_daisy_master;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Config A: defaults (8-bit words, 2 devices, div 10, setup 2)
  logic        a_cpol = 0, a_cpha = 0, a_dv = 0, a_miso;
  logic [15:0] a_data = '0;
  logic        a_ready, a_sclk, a_mosi, a_ss_n, a_active, a_o_dv;
  logic [15:0] a_o_data;

  // Config B: 12-bit words, 3 devices, div 1, setup 2
  logic        b_cpol = 0, b_cpha = 0, b_dv = 0, b_miso;
  logic [35:0] b_data = '0;
  logic        b_ready, b_sclk, b_mosi, b_ss_n, b_active, b_o_dv;
  logic [35:0] b_o_data;

  spi_daisy_master u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_cpol(a_cpol), .i_cpha(a_cpha), .i_data(a_data),
    .i_dv(a_dv), .i_miso(a_miso), .o_ready(a_ready), .o_sclk(a_sclk), .o_mosi(a_mosi),
    .o_ss_n(a_ss_n), .o_active(a_active), .o_data(a_o_data), .o_dv(a_o_dv)
  );

  spi_daisy_master #(.p_WORD_LEN(12), .p_NUM_DEV(3), .p_CLK_DIV(1), .p_CS_SETUP(2)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_cpol(b_cpol), .i_cpha(b_cpha), .i_data(b_data),
    .i_dv(b_dv), .i_miso(b_miso), .o_ready(b_ready), .o_sclk(b_sclk), .o_mosi(b_mosi),
    .o_ss_n(b_ss_n), .o_active(b_active), .o_data(b_o_data), .o_dv(b_o_dv)
  );

  // Slave chain models: the whole chain behaves as one shift register whose
  // MSB (last device) drives MISO and which captures MOSI on each sample edge.
  logic [15:0] a_pre = '0, chain_a = '0;
  logic        a_cpol_t = 0, a_cpha_t = 0, a_prev_sclk = 0, a_prev_low = 0;
  int          a_rise = 0, a_samp = 0;
  assign a_miso = chain_a[15];

  always @(negedge clk) begin
    if (!a_ss_n && !a_prev_low) chain_a = a_pre;
    else if (!a_ss_n && a_sclk != a_prev_sclk) begin
      if (a_sclk) a_rise++;
      if ((a_sclk != a_cpol_t) ^ a_cpha_t) begin
        chain_a = {chain_a[14:0], a_mosi};
        a_samp++;
      end
    end
    a_prev_sclk = a_sclk;
    a_prev_low  = !a_ss_n;
  end

  logic [35:0] b_pre = '0, chain_b = '0;
  logic        b_cpol_t = 0, b_cpha_t = 0, b_prev_sclk = 0, b_prev_low = 0;
  int          b_rise = 0, b_samp = 0;
  assign b_miso = chain_b[35];

  always @(negedge clk) begin
    if (!b_ss_n && !b_prev_low) chain_b = b_pre;
    else if (!b_ss_n && b_sclk != b_prev_sclk) begin
      if (b_sclk) b_rise++;
      if ((b_sclk != b_cpol_t) ^ b_cpha_t) begin
        chain_b = {chain_b[34:0], b_mosi};
        b_samp++;
      end
    end
    b_prev_sclk = b_sclk;
    b_prev_low  = !b_ss_n;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete frame on config A (sel=0) or B (sel=1), checked against
  // the chain exchange and the frame timing formulas.
  task automatic run_frame(input bit sel, input logic [35:0] data, input logic [1:0] mode,
                           input logic [35:0] pre);
    int cyc, low, exp_bits, exp_dv, r0, s0;
    logic [35:0] got, fin;
    bit seen;
    exp_bits = sel ? 36 : 16;
    exp_dv   = 1 + 2 * 2 + 2 * exp_bits * (sel ? 1 : 10);
    if (sel) begin
      b_pre = pre; b_cpol_t = mode[1]; b_cpha_t = mode[0]; r0 = b_rise; s0 = b_samp;
    end else begin
      a_pre = pre[15:0]; a_cpol_t = mode[1]; a_cpha_t = mode[0]; r0 = a_rise; s0 = a_samp;
    end
    @(negedge clk);
    if (sel) begin b_data = data; b_cpol = mode[1]; b_cpha = mode[0]; b_dv = 1'b1; end
    else begin a_data = data[15:0]; a_cpol = mode[1]; a_cpha = mode[0]; a_dv = 1'b1; end
    cyc = 0; low = 0; seen = 0; got = '0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      a_dv = 1'b0; b_dv = 1'b0;
      if (!(sel ? b_ss_n : a_ss_n)) low++;
      if (cyc == 1) begin
        chk_eq("setup_sclk", sel ? b_sclk : a_sclk, mode[1]);
        chk_eq("setup_active", sel ? b_active : a_active, 1);
        chk_eq("setup_ready", sel ? b_ready : a_ready, 0);
        if (!mode[0]) chk_eq("setup_mosi", sel ? b_mosi : a_mosi, sel ? data[35] : data[15]);
      end
      if (cyc == exp_dv - 1) chk_eq("hold_sclk", sel ? b_sclk : a_sclk, mode[1]);
      if (sel ? b_o_dv : a_o_dv) begin
        seen = 1;
        got = sel ? b_o_data : {20'h0, a_o_data};
        chk_eq("dv_ss_n", sel ? b_ss_n : a_ss_n, 1);
      end
    end
    chk_eq("dv_cycle", cyc, exp_dv);
    chk_eq("ss_low_cycles", low, exp_dv - 1);
    chk_eq("rx_data", got, sel ? pre : {20'h0, pre[15:0]});
    fin = sel ? chain_b : {20'h0, chain_a};
    chk_eq("chain_data", fin, sel ? data : {20'h0, data[15:0]});
    chk_eq("sclk_rises", (sel ? b_rise : a_rise) - r0, exp_bits);
    chk_eq("bits_sampled", (sel ? b_samp : a_samp) - s0, exp_bits);
    @(negedge clk);
    chk_eq("ready_back", sel ? b_ready : a_ready, 1);
    chk_eq("idle_sclk", sel ? b_sclk : a_sclk, mode[1]);
    chk_eq("dv_pulse_len", sel ? b_o_dv : a_o_dv, 0);
  endtask

  initial begin
    logic [15:0] d16, p16;
    logic [35:0] d36, p36;
    int cyc, n_dv, dv_at, gap, second_at, bad;

    repeat (3) @(negedge clk);
    chk_eq("rst_sclk", a_sclk, 0);
    chk_eq("rst_mosi", a_mosi, 0);
    chk_eq("rst_ss_n", a_ss_n, 1);
    chk_eq("rst_active", a_active, 0);
    chk_eq("rst_dv", a_o_dv, 0);
    chk_eq("rst_data", a_o_data, 0);
    chk_eq("rst_ready", a_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0 reference frame: dev1 preloaded 55, dev0 preloaded 00.
    run_frame(0, 36'hAAFF, SPI_MODE0, 36'h5500);
    chk_eq("dev1_word", chain_a[15:8], 8'hAA);
    chk_eq("dev0_word", chain_a[7:0], 8'hFF);

    run_frame(0, 36'h1234, SPI_MODE1, 36'(16'($urandom)));
    run_frame(0, 36'h1234, SPI_MODE2, 36'(16'($urandom)));
    run_frame(0, 36'h1234, SPI_MODE3, 36'(16'($urandom)));
    for (int i = 0; i < 4; i++)
      run_frame(0, 36'(16'($urandom)), 2'($urandom_range(0, 3)), 36'(16'($urandom)));

    // Three-device chain, fast clock.
    d36 = {12'hABC, 12'h123, 12'h5A5};
    run_frame(1, d36, SPI_MODE0, {12'h0F0, 12'h777, 12'hE1D});
    chk_eq("b_dev2_word", chain_b[35:24], 12'hABC);
    chk_eq("b_dev1_word", chain_b[23:12], 12'h123);
    chk_eq("b_dev0_word", chain_b[11:0], 12'h5A5);
    for (int i = 0; i < 3; i++) begin
      d36 = {4'($urandom), $urandom};
      p36 = {4'($urandom), $urandom};
      run_frame(1, d36, 2'($urandom_range(0, 3)), p36);
    end

    // Requests during SHIFT and on the o_dv cycle are dropped; the one after is taken.
    d16 = 16'($urandom); p16 = 16'($urandom) | 16'h1;
    a_pre = p16; a_cpol_t = 0; a_cpha_t = 0;
    @(negedge clk);
    a_data = d16; a_cpol = 0; a_cpha = 0; a_dv = 1'b1;
    cyc = 0; n_dv = 0; dv_at = 0; gap = 0; second_at = 0;
    while (n_dv < 2 && cyc < 1500) begin
      @(negedge clk);
      cyc++;
      a_dv = (cyc == 150);
      if (a_o_dv) begin
        n_dv++;
        chk_eq("ign_rx_data", a_o_data, p16);
        if (n_dv == 1) begin dv_at = cyc; a_dv = 1'b1; end
        else second_at = cyc;
      end
      if (n_dv == 1 && a_ss_n) gap++;
      if (n_dv == 1 && cyc == dv_at + 1) begin
        chk_eq("ign_dv_on_dv", a_ss_n, 1);
        chk_eq("ign_ready", a_ready, 1);
        a_dv = 1'b1;
      end
    end
    a_dv = 1'b0;
    chk_eq("ign_first_dv", dv_at, 325);
    chk_eq("ign_second_dv", second_at, dv_at + 1 + 325);
    chk_eq("ign_ss_gap", gap, 2);
    chk_eq("ign_chain", chain_a, d16);
    @(negedge clk);

    // Reset in the middle of SHIFT.
    a_pre = 16'($urandom); a_cpol_t = 1; a_cpha_t = 0;
    @(negedge clk);
    a_data = 16'($urandom); a_cpol = 1; a_cpha = 0; a_dv = 1'b1;
    @(negedge clk);
    a_dv = 1'b0;
    repeat (98) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("mid_rst_ss_n", a_ss_n, 1);
    chk_eq("mid_rst_sclk", a_sclk, 0);
    chk_eq("mid_rst_data", a_o_data, 0);
    chk_eq("mid_rst_ready", a_ready, 1);
    chk_eq("mid_rst_dv", a_o_dv, 0);
    chk_eq("mid_rst_mosi", a_mosi, 0);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (a_o_dv || !a_ss_n) bad++;
    end
    chk_eq("mid_rst_quiet", bad, 0);
    run_frame(0, 36'(16'($urandom)), SPI_MODE2, 36'(16'($urandom)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
